// File: rtl/read2feed.sv
// read2feed: read-side line feeder for the output-buffer RAM banks.
// Fetches one configured line word by word through the bank read ports,
// unpacks each 32-bit word into activations and streams them to the mesh.
//   clk, rst_n      clock, asynchronous active-low reset
//   conf_input      one-cycle configuration strobe (accepted in IDLE only)
//   st_addr         per-bank start address, bank j at [j*ADDR_LEN+:ADDR_LEN]
//   linelen         columns in the line
//   valid_mac       base bank index v
//   pair_mode       0 = byte beats, 1 = 4-byte (two half-word) beats
//   addrb/enb/doutb bank read port, bank (i,j) at index i*X_MAC+j
//   out_data_1      byte-mode beat, lane i at [i*8+:8]
//   out_data_4      pair-mode beat, lane i at [i*32+:32]
//   out_valid/out_ready/out_last  beat handshake, last marks final beat
//   busy            line in progress
//   done            one-cycle pulse after the final beat is accepted
module read2feed #(
   parameter int X_MAC        = 4,
   parameter int X_MESH       = 16,
   parameter int ADDR_LEN     = 13,
   parameter int DATA_LEN     = 32,
   parameter int MAX_LINE_LEN = 10,
   parameter int RD_LAT       = 2,
   parameter int BUFFER_NUM   = X_MAC*X_MESH
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           conf_input,
   input  logic [ADDR_LEN*X_MAC-1:0]      st_addr,
   input  logic [MAX_LINE_LEN-1:0]        linelen,
   input  logic [1:0]                     valid_mac,
   input  logic                           pair_mode,
   output logic [BUFFER_NUM*ADDR_LEN-1:0] addrb,
   output logic [BUFFER_NUM-1:0]          enb,
   input  logic [BUFFER_NUM*DATA_LEN-1:0] doutb,
   output logic [8*X_MESH-1:0]            out_data_1,
   output logic [32*X_MESH-1:0]           out_data_4,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic                           out_last,
   output logic                           busy,
   output logic                           done
);

   localparam int CW = $clog2(RD_LAT+1);

   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_EMIT, S_DONE} state_t;

   state_t                     state, state_nx;
   logic [ADDR_LEN*X_MAC-1:0]  st_q;
   logic [MAX_LINE_LEN-1:0]    len_q;
   logic [1:0]                 v_q;
   logic                       pair_q;
   logic [MAX_LINE_LEN:0]      beat_q;
   logic [CW-1:0]              wcnt_q;
   logic [DATA_LEN-1:0]        wlo_q [X_MESH];
   logic [DATA_LEN-1:0]        whi_q [X_MESH];
   logic [DATA_LEN-1:0]        dsel_lo [X_MESH];
   logic [DATA_LEN-1:0]        dsel_hi [X_MESH];

   logic [1:0]                 v2;
   logic [X_MAC-1:0]           row_en;
   logic [MAX_LINE_LEN:0]      beats;
   logic [MAX_LINE_LEN:0]      widx;
   logic                       accept, word_end, line_end, capture;

   assign v2       = (v_q == 2'(X_MAC-1)) ? 2'd0 : v_q + 2'd1;
   assign row_en   = (X_MAC'(1) << v_q) | (pair_q ? (X_MAC'(1) << v2) : '0);
   assign beats    = pair_q ? (({1'b0, len_q} + 1'b1) >> 1) : {1'b0, len_q};
   // beat_q already points at the next beat when a word is fetched
   assign widx     = pair_q ? (beat_q >> 1) : (beat_q >> 2);
   assign accept   = (state == S_EMIT) && out_ready;
   assign word_end = pair_q ? beat_q[0] : (beat_q[1:0] == 2'b11);
   assign line_end = (beat_q == beats - 1'b1);
   // doutb is valid RD_LAT cycles after the FETCH cycle
   assign capture  = (state == S_WAIT) && (wcnt_q == CW'(RD_LAT-1));

   always_comb begin
      for (int unsigned i = 0; i < X_MESH; i++) begin
         dsel_lo[i] = DATA_LEN'(doutb[i*X_MAC*DATA_LEN +: X_MAC*DATA_LEN] >> (v_q*DATA_LEN));
         dsel_hi[i] = DATA_LEN'(doutb[i*X_MAC*DATA_LEN +: X_MAC*DATA_LEN] >> (v2*DATA_LEN));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         st_q   <= '0;
         len_q  <= '0;
         v_q    <= '0;
         pair_q <= 1'b0;
         beat_q <= '0;
         wcnt_q <= '0;
         for (int unsigned i = 0; i < X_MESH; i++) begin
            wlo_q[i] <= '0;
            whi_q[i] <= '0;
         end
      end else begin
         state <= state_nx;
         if (state == S_IDLE && conf_input) begin
            st_q   <= st_addr;
            len_q  <= linelen;
            v_q    <= valid_mac;
            pair_q <= pair_mode;
            beat_q <= '0;
         end
         if (state == S_FETCH)
            wcnt_q <= '0;
         else if (state == S_WAIT)
            wcnt_q <= wcnt_q + 1'b1;
         if (capture) begin
            for (int unsigned i = 0; i < X_MESH; i++) begin
               wlo_q[i] <= dsel_lo[i];
               whi_q[i] <= dsel_hi[i];
            end
         end
         if (accept)
            beat_q <= beat_q + 1'b1;
      end
   end

   always_comb begin
      state_nx   = state;
      enb        = '0;
      addrb      = '0;
      out_data_1 = '0;
      out_data_4 = '0;
      out_valid  = 1'b0;
      out_last   = 1'b0;
      busy       = (state != S_IDLE);
      done       = 1'b0;
      case (state)
         S_IDLE:  if (conf_input) state_nx = S_FETCH;
         S_FETCH: begin
            // an empty line spends its FETCH cycle without reading
            if (len_q == '0) begin
               state_nx = S_DONE;
            end else begin
               state_nx = S_WAIT;
               for (int unsigned i = 0; i < X_MESH; i++) begin
                  enb[i*X_MAC +: X_MAC] = row_en;
                  for (int unsigned j = 0; j < X_MAC; j++) begin
                     if (row_en[j])
                        addrb[(i*X_MAC+j)*ADDR_LEN +: ADDR_LEN] =
                           st_q[j*ADDR_LEN +: ADDR_LEN] + ADDR_LEN'(widx);
                  end
               end
            end
         end
         S_WAIT:  if (capture) state_nx = S_EMIT;
         S_EMIT: begin
            out_valid = 1'b1;
            out_last  = line_end;
            for (int unsigned i = 0; i < X_MESH; i++) begin
               if (pair_q)
                  out_data_4[i*32 +: 32] = {16'(whi_q[i] >> {beat_q[0], 4'b0}),
                                            16'(wlo_q[i] >> {beat_q[0], 4'b0})};
               else
                  out_data_1[i*8 +: 8] = 8'(wlo_q[i] >> {beat_q[1:0], 3'b0});
            end
            if (accept) begin
               if (line_end)      state_nx = S_DONE;
               else if (word_end) state_nx = S_FETCH;
            end
         end
         S_DONE: begin
            done     = 1'b1;
            state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_read2feed.sv
module tb_read2feed;

   localparam int X_MAC = 4, X_MESH = 16, AL = 13, DL = 32, ML = 10, RD_LAT = 2;
   localparam int BN = X_MAC*X_MESH;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              conf_input = 1'b0;
   logic [AL*X_MAC-1:0] st_addr = '0;
   logic [ML-1:0]     linelen = '0;
   logic [1:0]        valid_mac = '0;
   logic              pair_mode = 1'b0;
   logic [BN*AL-1:0]  addrb;
   logic [BN-1:0]     enb;
   logic [BN*DL-1:0]  doutb;
   logic [8*X_MESH-1:0]  out_data_1;
   logic [32*X_MESH-1:0] out_data_4;
   logic              out_valid, out_last, busy, done;
   logic              out_ready = 1'b1;

   read2feed #(.X_MAC(X_MAC), .X_MESH(X_MESH), .ADDR_LEN(AL), .DATA_LEN(DL),
               .MAX_LINE_LEN(ML), .RD_LAT(RD_LAT)) dut (
      .clk(clk), .rst_n(rst_n), .conf_input(conf_input), .st_addr(st_addr),
      .linelen(linelen), .valid_mac(valid_mac), .pair_mode(pair_mode),
      .addrb(addrb), .enb(enb), .doutb(doutb), .out_data_1(out_data_1),
      .out_data_4(out_data_4), .out_valid(out_valid), .out_ready(out_ready),
      .out_last(out_last), .busy(busy), .done(done));

   always #5 clk = ~clk;

   int n_pass = 0, n_total = 0;

   task automatic chk(input string nm, input logic [831:0] act, input logic [831:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
   endtask

   // ---------------- RAM content model ----------------
   logic [31:0] ovr [int];
   logic [31:0] seed = 32'h1234_5678;

   function automatic logic [31:0] mem_word(input int bank, input logic [AL-1:0] a);
      logic [31:0] h;
      int key = bank*8192 + int'(a);
      if (ovr.exists(key)) return ovr[key];
      h = (32'(bank) * 32'h9E37_79B1) ^ (32'(a) * 32'h85EB_CA6B) ^ seed;
      return h ^ (h >> 15);
   endfunction

   logic [DL-1:0] pipe [RD_LAT][BN];
   always @(posedge clk) begin
      for (int b = 0; b < BN; b++) begin
         pipe[0][b] <= enb[b] ? mem_word(b, addrb[b*AL +: AL]) : $urandom;
         for (int s = 1; s < RD_LAT; s++) pipe[s][b] <= pipe[s-1][b];
      end
   end
   always_comb begin
      for (int b = 0; b < BN; b++) doutb[b*DL +: DL] = pipe[RD_LAT-1][b];
   end

   // ---------------- scoreboard ----------------
   typedef struct { logic [BN-1:0] en; logic [BN*AL-1:0] a; } fetch_t;
   typedef struct { logic [8*X_MESH-1:0] d1; logic [32*X_MESH-1:0] d4; logic last; } beat_t;
   fetch_t fq[$];
   beat_t  bq[$];

   logic done_pending = 1'b0;
   logic prev_stall = 1'b0;
   logic [8*X_MESH-1:0]  p_d1;
   logic [32*X_MESH-1:0] p_d4;
   logic p_last;

   always @(negedge clk) begin
      fetch_t f;
      beat_t  b;
      if (done_pending) begin
         chk("done_after_last", done, 1);
         done_pending = 1'b0;
      end
      if (out_last && !out_valid) chk("last_without_valid", out_valid, 1);
      if (enb != '0) begin
         if (fq.size() == 0) chk("spurious_enb", enb, 0);
         else begin
            f = fq.pop_front();
            chk("enb", enb, f.en);
            chk("addrb", addrb, f.a);
         end
      end
      if (out_valid) begin
         if (prev_stall) begin
            chk("stall_d1", out_data_1, p_d1);
            chk("stall_d4", out_data_4, p_d4);
            chk("stall_last", out_last, p_last);
         end
         if (out_ready) begin
            if (bq.size() == 0) chk("spurious_beat", out_valid, 0);
            else begin
               b = bq.pop_front();
               chk("data_1", out_data_1, b.d1);
               chk("data_4", out_data_4, b.d4);
               chk("last", out_last, b.last);
               if (b.last) done_pending = 1'b1;
            end
         end
      end else if (prev_stall) begin
         chk("stall_valid", out_valid, 1);
      end
      prev_stall = out_valid && !out_ready;
      p_d1 = out_data_1; p_d4 = out_data_4; p_last = out_last;
   end

   // ---------------- reference model + stimulus ----------------
   task automatic model(input logic [1:0] v, input logic pm, input int len,
                        input logic [AL*X_MAC-1:0] st);
      int nw = (len + 3) / 4;
      int nb = pm ? (len + 1) / 2 : len;
      int v2 = (int'(v) + 1) % X_MAC;
      for (int w = 0; w < nw; w++) begin
         fetch_t f;
         f.en = '0; f.a = '0;
         for (int i = 0; i < X_MESH; i++) begin
            for (int j = 0; j < X_MAC; j++) begin
               if (j == int'(v) || (pm && j == v2)) begin
                  f.en[i*X_MAC+j] = 1'b1;
                  f.a[(i*X_MAC+j)*AL +: AL] = st[j*AL +: AL] + AL'(w);
               end
            end
         end
         fq.push_back(f);
      end
      for (int k = 0; k < nb; k++) begin
         beat_t b;
         logic [31:0] wa, wb;
         b.d1 = '0; b.d4 = '0;
         b.last = (k == nb - 1);
         for (int i = 0; i < X_MESH; i++) begin
            if (!pm) begin
               wa = mem_word(i*X_MAC + int'(v), st[int'(v)*AL +: AL] + AL'(k/4));
               b.d1[i*8 +: 8] = wa[(k%4)*8 +: 8];
            end else begin
               wa = mem_word(i*X_MAC + int'(v), st[int'(v)*AL +: AL] + AL'(k/2));
               wb = mem_word(i*X_MAC + v2, st[v2*AL +: AL] + AL'(k/2));
               b.d4[i*32 +: 32] = {wb[(k%2)*16 +: 16], wa[(k%2)*16 +: 16]};
            end
         end
         bq.push_back(b);
      end
   endtask

   task automatic start_line(input logic [1:0] v, input logic pm, input int len,
                             input logic [AL*X_MAC-1:0] st);
      int n;
      model(v, pm, len, st);
      @(posedge clk); #1;
      st_addr = st; linelen = ML'(len); valid_mac = v; pair_mode = pm; conf_input = 1'b1;
      @(posedge clk); #1;
      conf_input = 1'b0;
      if (len > 0) begin
         n = 1;
         while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
         chk("first_valid_latency", n, 4);
      end
   endtask

   task automatic wait_done();
      int n = 0;
      while (!done && n < 3000) begin @(posedge clk); #1; n++; end
      chk("done_seen", done, 1);
   endtask

   logic rand_ready = 1'b0;
   initial forever begin
      @(posedge clk); #1;
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
   end

   initial begin
      logic [AL*X_MAC-1:0] st;
      // reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", out_valid, 0);
      chk("rst_enb", enb, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_addrb", addrb, 0);
      chk("rst_last", out_last, 0);
      chk("rst_d1", out_data_1, 0);
      rst_n = 1'b1;

      // byte mode, bank 1
      for (int i = 0; i < X_MESH; i++) begin
         ovr[(i*4+1)*8192 + 16'h10] = 32'h4433_2211;
         ovr[(i*4+1)*8192 + 16'h11] = 32'h8877_6655;
      end
      st = '0; st[1*AL +: AL] = 13'h10;
      start_line(2'd1, 1'b0, 6, st);
      wait_done();

      // pair mode with bank wrap 3 -> 0
      for (int i = 0; i < X_MESH; i++) begin
         ovr[(i*4+3)*8192 + 16'h20] = 32'hBBBB_AAAA;
         ovr[(i*4+0)*8192 + 16'h20] = 32'hDDDD_CCCC;
         ovr[(i*4+3)*8192 + 16'h21] = 32'h1111_1111;
         ovr[(i*4+0)*8192 + 16'h21] = 32'h2222_2222;
      end
      st = {4{13'h20}};
      start_line(2'd3, 1'b1, 5, st);
      wait_done();

      // backpressure mid-line
      st = {13'h0A1, 13'h055, 13'h100, 13'h033};
      start_line(2'd2, 1'b0, 12, st);
      repeat (2) @(posedge clk);
      #1; out_ready = 1'b0;
      repeat (5) @(posedge clk);
      #1; out_ready = 1'b1;
      wait_done();

      // empty line
      start_line(2'd0, 1'b0, 0, '0);
      chk("len0_busy_c1", busy, 1);
      chk("len0_done_c1", done, 0);
      @(posedge clk); #1;
      chk("len0_busy_c2", busy, 1);
      chk("len0_done_c2", done, 1);
      @(posedge clk); #1;
      chk("len0_busy_c3", busy, 0);
      chk("len0_done_c3", done, 0);

      // address wrap
      st = '0; st[2*AL +: AL] = 13'h1FFF;
      start_line(2'd2, 1'b0, 8, st);
      wait_done();

      // async reset mid-EMIT
      st = {4{13'h0400}};
      start_line(2'd0, 1'b0, 24, st);
      repeat (3) @(posedge clk);
      #2; rst_n = 1'b0;
      #1;
      chk("arst_valid", out_valid, 0);
      chk("arst_enb", enb, 0);
      chk("arst_busy", busy, 0);
      chk("arst_done", done, 0);
      fq.delete(); bq.delete();
      done_pending = 1'b0; prev_stall = 1'b0;
      @(posedge clk); #1; rst_n = 1'b1;
      start_line(2'd1, 1'b1, 7, st);
      wait_done();

      // randomized lines with random backpressure
      rand_ready = 1'b1;
      for (int t = 0; t < 25; t++) begin
         st = AL*X_MAC'({$urandom, $urandom});
         start_line(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    $urandom_range(1, 40), st);
         wait_done();
      end
      rand_ready = 1'b0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("fetch_queue_empty", fq.size(), 0);
      chk("beat_queue_empty", bq.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
